// File: rtl/pattern_serializer.sv
// pattern_serializer: parallel-to-serial front end for the serial
// pattern-recognition FSMs. Accepts W-bit words on a valid/ready handshake
// and emits one bit per cycle in which bit_en is high. A new word can be
// loaded on the same edge that consumes the last bit of the current word,
// so consecutive words reach the detector with no gap between them.
//
// Build option: define SER_LSB_FIRST_EN to emit each word LSB first
// (shift right). When it is undefined, words are emitted MSB first.
// Handshake and timing are identical in both builds.
module pattern_serializer #(
  parameter int   W        = 8,
  parameter logic IDLE_BIT = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         bit_en,
  output logic         bit_out,
  output logic         bit_valid,
  output logic         word_done,
  output logic         busy
);

  localparam int CW = $clog2(W);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          state_reg;
  logic [W-1:0]    shift_reg;
  logic [CW-1:0]   count_reg;
  logic            word_done_reg;
  logic            last_bit;
  logic            accept;
  logic [W-1:0]    shift_next;
  logic            head_bit;

  // Orientation of the word on the serial line.
`ifdef SER_LSB_FIRST_EN
  assign shift_next = shift_reg >> 1;
  assign head_bit   = shift_reg[0];
`else
  assign shift_next = shift_reg << 1;
  assign head_bit   = shift_reg[W-1];
`endif

  // Last bit of a word is leaving this cycle; the slot frees up on this edge.
  assign last_bit = (state_reg == SHIFT) && (count_reg == '0) && bit_en;
  assign in_ready = (state_reg == IDLE) || last_bit;
  assign accept   = in_valid && in_ready;

  assign bit_valid = (state_reg == SHIFT);
  assign busy      = (state_reg == SHIFT);
  assign bit_out   = (state_reg == SHIFT) ? head_bit : IDLE_BIT;
  assign word_done = word_done_reg;

  // Control FSM: load on accept, shift on bit_en, reload or idle after the last bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      count_reg     <= '0;
      word_done_reg <= 1'b0;
    end else begin
      word_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            shift_reg <= in_data;
            count_reg <= CW'(W - 1);
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_en) begin
            if (count_reg == '0) begin
              word_done_reg <= 1'b1;
              if (accept) begin
                shift_reg <= in_data;
                count_reg <= CW'(W - 1);
              end else begin
                shift_reg <= shift_next;
                state_reg <= IDLE;
              end
            end else begin
              shift_reg <= shift_next;
              count_reg <= count_reg - 1'b1;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
